// File: rtl/sprite_linebuf.sv
// Double-buffered sprite line buffer: renders 8-pixel ROM slices into the write bank
// while the read bank is scanned out (and cleared) for the priority mixer.
`timescale 1ns/1ps
module sprite_linebuf #(
  parameter int XW = 8,
  parameter int PW = 4,
  parameter int CW = 4
) (
  input  logic              clk_49m,
  input  logic              reset,
  input  logic              cen_6m,
  input  logic              line_start,
  input  logic              ocol_n,
  input  logic              odat_n,
  input  logic              ocs,
  input  logic              oflp,
  input  logic [XW-1:0]     sprite_x,
  input  logic [CW-1:0]     sprite_col,
  input  logic [8*PW-1:0]   pix_data,
  input  logic [XW-1:0]     rd_x,
  output logic [CW+PW-1:0]  sprite_pix,
  output logic              clr_busy
);

  localparam int DEPTH = 1 << XW;
  localparam int EW    = CW + PW;
  localparam logic [XW-1:0] X_ONE = {{(XW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_SHIFT} state_t;

  state_t            state_q, state_d;
  logic [XW-1:0]     clr_addr_q, clr_addr_d;
  logic              clr_busy_q, clr_busy_d;
  logic              bank_sel_q, bank_sel_d;
  logic [XW-1:0]     wx_q, wx_d;
  logic [CW-1:0]     col_q, col_d;
  logic              skip_q, skip_d;
  logic              flp_q, flp_d;
  logic [8*PW-1:0]   sr_q, sr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [EW-1:0]     pix_q, pix_d;

  // bank_sel_q selects the write bank; the other bank is read out
  logic [EW-1:0]     mem0_q [DEPTH];
  logic [EW-1:0]     mem1_q [DEPTH];

  logic [EW-1:0]     wr_ent, rd_ent;
  logic [PW-1:0]     emit_pix;
  logic              we_clr, we_rdclr, we_pix;

  assign wr_ent   = bank_sel_q ? mem1_q[wx_q] : mem0_q[wx_q];
  assign rd_ent   = bank_sel_q ? mem0_q[rd_x] : mem1_q[rd_x];
  assign emit_pix = flp_q ? sr_q[8*PW-1 -: PW] : sr_q[PW-1:0];

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_busy_d = clr_busy_q;
    bank_sel_d = bank_sel_q;
    wx_d       = wx_q;
    col_d      = col_q;
    skip_d     = skip_q;
    flp_d      = flp_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    pix_d      = pix_q;
    we_clr     = 1'b0;
    we_rdclr   = 1'b0;
    we_pix     = 1'b0;
    if (state_q == ST_CLEAR) begin
      we_clr     = 1'b1;
      clr_addr_d = clr_addr_q + X_ONE;
      if (&clr_addr_q) begin
        state_d    = ST_IDLE;
        clr_busy_d = 1'b0;
      end
    end else if (cen_6m) begin
      pix_d    = rd_ent;
      we_rdclr = 1'b1;
      if (line_start) begin
        bank_sel_d = ~bank_sel_q;
        state_d    = ST_IDLE;
        cnt_d      = '0;
      end
      if (!ocol_n) begin
        wx_d    = sprite_x;
        col_d   = sprite_col;
        skip_d  = ocs;
        flp_d   = oflp;
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      // A load wins over both aborts so it lands in the freshly selected bank
      if (!odat_n) begin
        sr_d    = pix_data;
        cnt_d   = 4'd8;
        state_d = ST_SHIFT;
      end else if (state_q == ST_SHIFT && !line_start && ocol_n) begin
        we_pix = (emit_pix != '0) && !skip_q && (wr_ent == '0);
        sr_d   = flp_q ? (sr_q << PW) : (sr_q >> PW);
        wx_d   = wx_q + X_ONE;
        cnt_d  = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk_49m) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      clr_busy_q <= 1'b1;
      bank_sel_q <= 1'b0;
      wx_q       <= '0;
      col_q      <= '0;
      skip_q     <= 1'b0;
      flp_q      <= 1'b0;
      sr_q       <= '0;
      cnt_q      <= '0;
      pix_q      <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      clr_busy_q <= clr_busy_d;
      bank_sel_q <= bank_sel_d;
      wx_q       <= wx_d;
      col_q      <= col_d;
      skip_q     <= skip_d;
      flp_q      <= flp_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      pix_q      <= pix_d;
    end
  end

  // Storage is not reset; the CLEAR sweep zeroes it instead
  always_ff @(posedge clk_49m) begin
    if (!reset) begin
      if (we_clr) begin
        mem0_q[clr_addr_q] <= '0;
        mem1_q[clr_addr_q] <= '0;
      end
      if (we_rdclr) begin
        if (bank_sel_q) mem0_q[rd_x] <= '0;
        else            mem1_q[rd_x] <= '0;
      end
      if (we_pix) begin
        if (bank_sel_q) mem1_q[wx_q] <= {col_q, emit_pix};
        else            mem0_q[wx_q] <= {col_q, emit_pix};
      end
    end
  end

  assign sprite_pix = pix_q;
  assign clr_busy   = clr_busy_q;

endmodule

// File: tb/tb_sprite_linebuf.sv
// Bench for sprite_linebuf: directed vector table, hand sequences for corner cases,
// and randomized lines checked against a sprite-level line buffer model.
`timescale 1ns/1ps
module tb_sprite_linebuf;

  logic        clk_49m = 1'b0;
  logic        reset = 1'b1;
  logic        cen_6m = 1'b0;
  logic        line_start = 1'b0;
  logic        ocol_n = 1'b1;
  logic        odat_n = 1'b1;
  logic        ocs = 1'b0;
  logic        oflp = 1'b0;
  logic [7:0]  sprite_x = '0;
  logic [3:0]  sprite_col = '0;
  logic [31:0] pix_data = '0;
  logic [7:0]  rd_x = '0;
  logic [7:0]  sprite_pix;
  logic        clr_busy;

  sprite_linebuf #(.XW(8), .PW(4), .CW(4)) dut (
    .clk_49m(clk_49m), .reset(reset), .cen_6m(cen_6m), .line_start(line_start),
    .ocol_n(ocol_n), .odat_n(odat_n), .ocs(ocs), .oflp(oflp),
    .sprite_x(sprite_x), .sprite_col(sprite_col), .pix_data(pix_data),
    .rd_x(rd_x), .sprite_pix(sprite_pix), .clr_busy(clr_busy)
  );

  always #5 clk_49m = ~clk_49m;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_line [256];

  // Reference model: two banks of {colour,pixel}, the write bank index, latched sprite state
  int mb [2][256];
  int msel = 0;
  int mwx = 0, mcol = 0, mskip = 0, mflp = 0;

  typedef struct {
    logic [7:0]  x;
    logic [3:0]  col;
    logic        sk;
    logic        fl;
    logic [31:0] pix;
    int          nload;
    logic [7:0]  exp0;
    int          estep;
    int          nexp;
  } vec_t;
  vec_t vecs [4];

  task automatic check8(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic cen_step(input logic ls, input logic ocol, input logic odat, input logic [7:0] rx);
    line_start = ls;
    ocol_n = ~ocol;
    odat_n = ~odat;
    rd_x = rx;
    cen_6m = 1'b1;
    @(posedge clk_49m); #1;
    cen_6m = 1'b0;
    line_start = 1'b0;
    ocol_n = 1'b1;
    odat_n = 1'b1;
    repeat (7) @(posedge clk_49m);
    #1;
  endtask

  task automatic zero_exp();
    for (int i = 0; i < 256; i++) exp_line[i] = 8'h00;
  endtask

  task automatic sweep(input string nm);
    for (int x = 0; x < 256; x++) begin
      cen_step(1'b0, 1'b0, 1'b0, 8'(x));
      check8(nm, x, sprite_pix, exp_line[x]);
    end
  endtask

  task automatic reset_and_clear(input string nm);
    int n;
    reset = 1'b1;
    @(posedge clk_49m); #1;
    check8({nm, "_rst_pix"}, 0, sprite_pix, 8'h00);
    check8({nm, "_rst_busy"}, 0, {7'd0, clr_busy}, 8'h01);
    reset = 1'b0;
    n = 0;
    while (clr_busy === 1'b1 && n < 1000) begin
      @(posedge clk_49m); #1;
      n++;
    end
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL %s_busy_len: got %0d cycles expected 256", nm, n);
    end
  endtask

  task automatic render(input logic [7:0] x, input logic [3:0] col, input logic sk,
                        input logic fl, input logic [31:0] pix, input int nload);
    sprite_x = x; sprite_col = col; ocs = sk; oflp = fl;
    cen_step(1'b0, 1'b1, 1'b0, 8'h00);
    pix_data = pix;
    for (int i = 0; i < nload; i++) begin
      cen_step(1'b0, 1'b0, 1'b1, 8'h00);
      repeat (8) cen_step(1'b0, 1'b0, 1'b0, 8'h00);
    end
  endtask

  task automatic model_load(input logic [31:0] pix);
    for (int i = 0; i < 8; i++) begin
      int p;
      int xx;
      p  = mflp != 0 ? int'(pix[4*(7-i) +: 4]) : int'(pix[4*i +: 4]);
      xx = (mwx + i) % 256;
      if (p != 0 && mskip == 0 && mb[msel][xx] == 0) mb[msel][xx] = mcol * 16 + p;
    end
    mwx = (mwx + 8) % 256;
  endtask

  task automatic run_line(input int busy);
    bit          s_ocol [257];
    bit          s_odat [257];
    logic [7:0]  s_x    [257];
    logic [3:0]  s_col  [257];
    bit          s_sk   [257];
    bit          s_fl   [257];
    logic [31:0] s_pix  [257];
    int c, ld, nl, rx, expv;
    for (int i = 0; i < 257; i++) begin
      s_ocol[i] = 0; s_odat[i] = 0; s_x[i] = '0; s_col[i] = '0;
      s_sk[i] = 0; s_fl[i] = 0; s_pix[i] = '0;
    end
    if (busy != 0) begin
      c = 1;
      while (c < 220) begin
        s_ocol[c] = 1;
        s_x[c]    = 8'($urandom);
        s_col[c]  = 4'($urandom);
        s_sk[c]   = ($urandom % 4) == 0;
        s_fl[c]   = 1'($urandom);
        ld = (($urandom % 2) == 0) ? c : c + 1;
        s_odat[ld] = 1;
        s_pix[ld]  = $urandom & $urandom;
        nl = 1 + ($urandom % 2);
        if (nl == 2) begin
          s_odat[ld + 9] = 1;
          s_pix[ld + 9]  = $urandom & $urandom;
        end
        c = ld + 9 * nl + int'($urandom % 4);
      end
    end
    rx = int'($urandom % 256);
    expv = mb[1 - msel][rx];
    mb[1 - msel][rx] = 0;
    cen_step(1'b1, 1'b0, 1'b0, 8'(rx));
    check8("rand_swap", rx, sprite_pix, 8'(expv));
    msel = 1 - msel;
    for (int k = 1; k < 257; k++) begin
      if (s_ocol[k]) begin
        sprite_x = s_x[k]; sprite_col = s_col[k]; ocs = s_sk[k]; oflp = s_fl[k];
        mwx = int'(s_x[k]); mcol = int'(s_col[k]); mskip = int'(s_sk[k]); mflp = int'(s_fl[k]);
      end
      if (s_odat[k]) pix_data = s_pix[k];
      expv = mb[1 - msel][k - 1];
      mb[1 - msel][k - 1] = 0;
      cen_step(1'b0, s_ocol[k], s_odat[k], 8'(k - 1));
      if (s_odat[k]) model_load(s_pix[k]);
      check8("rand_rd", k - 1, sprite_pix, 8'(expv));
    end
  endtask

  initial begin
    vecs[0] = '{8'h10, 4'h5, 1'b0, 1'b0, 32'h87654321, 1, 8'h51,  1,  8};
    vecs[1] = '{8'h10, 4'h5, 1'b0, 1'b1, 32'h87654321, 1, 8'h58, -1,  8};
    vecs[2] = '{8'h10, 4'h5, 1'b1, 1'b0, 32'h87654321, 1, 8'h00,  0,  0};
    vecs[3] = '{8'hFC, 4'h3, 1'b0, 1'b0, 32'h11111111, 2, 8'h31,  0, 16};
    for (int b = 0; b < 2; b++) for (int i = 0; i < 256; i++) mb[b][i] = 0;

    repeat (3) @(posedge clk_49m);
    #1;
    reset_and_clear("init");
    zero_exp();
    sweep("clr_bankA");
    cen_step(1'b1, 1'b0, 1'b0, 8'h00);
    sweep("clr_bankB");

    // Directed single-sprite vectors
    for (int t = 0; t < 4; t++) begin
      render(vecs[t].x, vecs[t].col, vecs[t].sk, vecs[t].fl, vecs[t].pix, vecs[t].nload);
      cen_step(1'b1, 1'b0, 1'b0, 8'h00);
      zero_exp();
      for (int k = 0; k < vecs[t].nexp; k++)
        exp_line[(int'(vecs[t].x) + k) % 256] = 8'(int'(vecs[t].exp0) + k * vecs[t].estep);
      sweep($sformatf("vec%0d", t));
      zero_exp();
      sweep($sformatf("vec%0d_reread", t));
    end

    // Transparency and first-drawn priority
    render(8'h20, 4'h1, 1'b0, 1'b0, 32'h00000011, 1);
    render(8'h1F, 4'h2, 1'b0, 1'b0, 32'h22222222, 1);
    cen_step(1'b1, 1'b0, 1'b0, 8'h00);
    zero_exp();
    exp_line[8'h1F] = 8'h22;
    exp_line[8'h20] = 8'h11;
    exp_line[8'h21] = 8'h11;
    for (int x = 8'h22; x <= 8'h26; x++) exp_line[x] = 8'h22;
    sweep("prio");

    // Load on the same cen as line_start goes to the new write bank
    sprite_x = 8'h80; sprite_col = 4'h7; ocs = 1'b0; oflp = 1'b0;
    cen_step(1'b0, 1'b1, 1'b0, 8'h00);
    pix_data = 32'h99999999;
    cen_step(1'b1, 1'b0, 1'b1, 8'h00);
    repeat (8) cen_step(1'b0, 1'b0, 1'b0, 8'h00);
    cen_step(1'b1, 1'b0, 1'b0, 8'h00);
    zero_exp();
    for (int x = 8'h80; x <= 8'h87; x++) exp_line[x] = 8'h79;
    sweep("ls_load");

    // Reset in the middle of a shift
    render(8'h50, 4'h6, 1'b0, 1'b0, 32'h66666666, 1);
    cen_step(1'b1, 1'b0, 1'b0, 8'h00);
    sprite_x = 8'h60; sprite_col = 4'h7;
    cen_step(1'b0, 1'b1, 1'b0, 8'h00);
    pix_data = 32'h77777777;
    cen_step(1'b0, 1'b0, 1'b1, 8'h00);
    repeat (3) cen_step(1'b0, 1'b0, 1'b0, 8'h00);
    reset_and_clear("midshift");
    check8("midshift_bank_sel", 0, {7'd0, dut.bank_sel_q}, 8'h00);
    zero_exp();
    sweep("midshift_rdA");
    cen_step(1'b1, 1'b0, 1'b0, 8'h00);
    sweep("midshift_rdB");

    // Randomized lines against the model; both banks are clean here
    for (int b = 0; b < 2; b++) for (int i = 0; i < 256; i++) mb[b][i] = 0;
    msel = 0;
    for (int l = 0; l < 5; l++) run_line(l < 4 ? 1 : 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_linebuf.md
Name: sprite_linebuf

Overview:
- Double-buffered sprite line buffer. It sits directly downstream of the sprite address generator (OCS/OFLP/ODAT/OCOL outputs) and the sprite ROMs.
- During line N it renders the 8-pixel ROM slices of every sprite on that line into the write bank. In parallel, it reads out and clears the read bank, which holds line N-1.
- The read bank's pixel output feeds the sprite/tile priority mixer.

Parameters:
- XW, 8, width of the X coordinate; each bank is 2**XW entries.
- PW, 4, width of the pixel code from the sprite ROM; 0 is transparent.
- CW, 4, width of the sprite colour attribute.

Ports:
- clk_49m  in  1  master clock
- reset  in  1  synchronous active-high reset
- cen_6m  in  1  pixel clock enable; one clk_49m cycle wide
- line_start  in  1  one-cen pulse at start of line; swaps banks
- ocol_n  in  1  active low; latch sprite_x, sprite_col, ocs, oflp (new sprite)
- odat_n  in  1  active low; load pix_data (8 pixels) and start the shift-out
- ocs  in  1  1 = sprite not on this line; suppresses writes for this sprite
- oflp  in  1  horizontal flip for this sprite
- sprite_x  in  XW  start X of sprite
- sprite_col  in  CW  colour attribute
- pix_data  in  8*PW  8 pixels; pixel 0 is in bits [PW-1:0]
- rd_x  in  XW  readout X, from the horizontal counter
- sprite_pix  out  CW+PW  {colour, pixel} at rd_x; 0 = no sprite
- clr_busy  out  1  high during the post-reset bank clear

Behaviour:
- All strobes and state changes are qualified by cen_6m, except the clear sweep, which runs at clk_49m.
- Reset, taking effect on the next clk_49m edge:
  - bank_sel=0, FSM=CLEAR, sprite_pix=0, clr_busy=1.
  - Latched x, colour, ocs and oflp are 0; the shift count is 0.
  - Reset asserted mid-operation restarts CLEAR from address 0 and drops any in-flight shift.
- CLEAR:
  - Writes 0 to address k of both banks on each clk_49m cycle, k=0..2**XW-1.
  - Then goes to IDLE and deasserts clr_busy on the cycle after the last write.
  - While in CLEAR: strobes are ignored, sprite_pix holds 0, line_start does not swap banks.
- Sprite latch:
  - On cen with ocol_n=0: wx<=sprite_x, col<=sprite_col, skip<=ocs, flp<=oflp.
  - Any in-progress shift is aborted.
- Shift-out:
  - On cen with odat_n=0: load the 8-pixel shift register, cnt<=8, FSM=SHIFT.
  - A load that arrives during SHIFT reloads the register and count (restart). wx is kept, not reset.
  - Each SHIFT cen emits one pixel, pixel 0 first, or pixel 7 first if flp=1.
  - If pixel!=0, skip=0, and the write-bank entry at wx is 0, write {col,pixel}. An earlier-drawn sprite therefore wins priority.
  - Every emitted pixel increments wx modulo 2**XW; writes wrap from 255 to 0.
  - cnt decrements; FSM returns to IDLE after the 8th pixel.
  - The two slices of a 16-wide sprite land at consecutive X because wx persists between odat_n loads.
- Simultaneous ocol_n and odat_n on the same cen: the latch happens first, then the load uses the new attributes.
- Readout:
  - Each cen: sprite_pix <= read_bank[rd_x], latency 1 cen.
  - The same cen clears read_bank[rd_x] to 0, so each location reads once per line.
  - The read bank and write bank are always distinct, so there are no read/write collisions.
- Line swap:
  - On cen with line_start=1 (not in CLEAR): bank_sel toggles, and the FSM aborts to IDLE with cnt=0.
  - The new write bank is the one just read-cleared.
  - line_start on the same cen as odat_n: the swap takes effect and the load goes to the new write bank.
- The read-modify-write to the write bank must complete within one cen period (8 clk_49m cycles).

Test Plan:
- Reset, then hold reset low: clr_busy stays 1 for exactly 256 clk_49m cycles. Afterwards, a full line of readout gives sprite_pix=0 at every rd_x.
- Write path:
  - Stimulus: ocol_n with sprite_x=0x10, col=0x5, ocs=0, oflp=0; odat_n with pix_data=0x87654321; line_start; sweep rd_x.
  - Required: X 0x10..0x17 read 0x51,0x52,...,0x58, one cen after each rd_x.
  - A second sweep of the same bank reads all 0.
- Same stimulus with oflp=1 -> X 0x10..0x17 read 0x58 down to 0x51.
- ocs=1 sprite -> nothing written; all 0 on readout.
- Transparency and priority:
  - Sprite A: col=1 at X 0x20, pixels 0x00000011.
  - Sprite B: col=2 at X 0x1F, pixels 0x22222222.
  - Required: 0x1F=0x22, 0x20=0x11, 0x21=0x11, 0x22..0x26=0x22.
- Wrap:
  - Stimulus: sprite_x=0xFC, two odat_n loads of 0x11111111.
  - Required: X 0xFC..0xFF and 0x00..0x0B all read {col,1}.
- Assert reset mid-SHIFT -> clear restarts, no partial write survives, and bank_sel=0 afterwards.
